// File: rtl/alu_bist_seq.sv
// alu_bist_seq: self-test sequencer for the 8-bit ALU. It sweeps every opcode with
// LFSR operand pairs, folds each result into a 16-bit MISR and, at the end of the
// sweep, compares the signature against a golden value.
module alu_bist_seq #(
    parameter int          NUM_OPS    = 14,
    parameter int          ROUNDS     = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [3:0]  alu_ctrl,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_y,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    localparam int         RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [3:0] OP_NOP = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_lfsr;
    logic [15:0]     r_misr;
    logic [3:0]      r_op;
    logic [RW-1:0]   r_round;
    logic [3:0]      r_ctrl;
    logic [7:0]      r_x;
    logic [7:0]      r_y;
    logic            r_pass;

    logic            w_start;
    logic            w_capture;
    logic            w_abort_run;
    logic            w_round_wrap;
    logic            w_last;
    logic            w_carry_in;
    logic [15:0]     w_lfsr_next;
    logic [15:0]     w_misr_next;
    logic [3:0]      w_op_next;
    logic [RW-1:0]   w_round_next;

    assign w_round_wrap = (r_round == RW'(ROUNDS - 1));
    assign w_last       = (r_op == 4'(NUM_OPS - 1)) && w_round_wrap;
    assign w_lfsr_next  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    // Carry is only meaningful for Add (0) and Sub (1); other opcodes contribute 0.
    assign w_carry_in   = (r_op <= 4'd1) ? alu_carry : 1'b0;
    assign w_misr_next  = {r_misr[14:0], r_misr[15] ^ r_misr[13] ^ r_misr[12] ^ r_misr[10]}
                          ^ {7'b0, w_carry_in, alu_out};
    assign w_op_next    = w_round_wrap ? (r_op + 4'd1) : r_op;
    assign w_round_next = w_round_wrap ? '0 : (r_round + RW'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the one-cycle strobes that steer the datapath
    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_abort_run = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_next  = S_APPLY;
                    w_start = 1'b1;
                end
            end
            S_APPLY: begin
                if (abort) begin
                    w_next      = S_IDLE;
                    w_abort_run = 1'b1;
                end else begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    w_next      = S_IDLE;
                    w_abort_run = 1'b1;
                end else begin
                    w_capture = 1'b1;
                    w_next    = w_last ? S_DONE : S_APPLY;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: vector generation, signature compaction and the pass flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr  <= '0;
            r_misr  <= '0;
            r_op    <= '0;
            r_round <= '0;
            r_ctrl  <= OP_NOP;
            r_x     <= '0;
            r_y     <= '0;
            r_pass  <= 1'b0;
        end else if (w_start) begin
            r_lfsr  <= LFSR_SEED;
            r_misr  <= '0;
            r_op    <= '0;
            r_round <= '0;
            r_ctrl  <= 4'd0;
            r_x     <= LFSR_SEED[15:8];
            r_y     <= LFSR_SEED[7:0];
            r_pass  <= 1'b0;
        end else if (w_capture) begin
            r_misr <= w_misr_next;
            if (w_last) begin
                r_ctrl <= OP_NOP;
                r_x    <= '0;
                r_y    <= '0;
            end else begin
                r_lfsr  <= w_lfsr_next;
                r_op    <= w_op_next;
                r_round <= w_round_next;
                r_ctrl  <= w_op_next;
                r_x     <= w_lfsr_next[15:8];
                r_y     <= w_lfsr_next[7:0];
            end
        end else if (w_abort_run) begin
            r_ctrl <= OP_NOP;
            r_x    <= '0;
            r_y    <= '0;
            r_pass <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_pass <= (r_misr == GOLDEN_SIG);
        end
    end

    assign alu_ctrl  = r_ctrl;
    assign alu_x     = r_x;
    assign alu_y     = r_y;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign pass      = r_pass;
    assign signature = r_misr;

endmodule

// File: tb/tb_alu_bist_seq.sv
// Bench for alu_bist_seq: an ALU behavioural model feeds the DUT, a vector-level
// model predicts every output cycle by cycle, and directed checks pin key points.
module tb_alu_bist_seq;

    localparam int         NOPS   = 14;
    localparam int         NRND   = 16;
    localparam int         NVEC   = NOPS * NRND;
    localparam int         RUNLEN = 2 * NVEC;
    localparam int         FAULTV = 4 * NRND + 3;
    localparam logic [3:0] NOP    = 4'b1101;

    // Behavioural 8-bit ALU: returns {carry, result}; carry outside Add/Sub is junk on purpose
    function automatic logic [8:0] aluModel(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        logic [8:0] r;
        case (op)
            4'd0:    r = {1'b0, x} + {1'b0, y};
            4'd1:    r = {1'b0, x} - {1'b0, y};
            4'd2:    r = {x[7], x & y};
            4'd3:    r = {y[0], x | y};
            4'd4:    r = {x[0], x ^ y};
            4'd5:    r = {1'b1, ~x};
            4'd6:    r = {x[7], x[6:0], 1'b0};
            4'd7:    r = {x[0], 1'b0, x[7:1]};
            4'd8:    r = {y[3], x[6:0], x[7]};
            4'd9:    r = {y[5], x[0], x[7:1]};
            4'd10:   r = {1'b1, x + 8'd1};
            4'd11:   r = {x[2], x - 8'd1};
            4'd12:   r = {x[1], y};
            default: r = 9'd0;
        endcase
        aluModel = r;
    endfunction

    // Expected final signature of a whole sweep, vector by vector
    function automatic logic [15:0] computeSig(input bit fault);
        logic [15:0] l;
        logic [15:0] m;
        logic [8:0]  r;
        logic [3:0]  op;
        l = 16'hACE1;
        m = 16'h0000;
        for (int i = 0; i < NVEC; i++) begin
            op = 4'(i / NRND);
            r  = aluModel(op, l[15:8], l[7:0]);
            if (fault && i == FAULTV) r[0] = ~r[0];
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {7'b0, (op <= 4'd1) ? r[8] : 1'b0, r[7:0]};
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        computeSig = m;
    endfunction

    localparam logic [15:0] GOLDEN = computeSig(1'b0);

    logic        clk;
    logic        rstN;
    logic        start;
    logic        abort;
    logic [3:0]  aluCtrl;
    logic [7:0]  aluX;
    logic [7:0]  aluY;
    logic [7:0]  aluOut;
    logic        aluCarry;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;

    logic [15:0] lfsrVec   [0:NVEC-1];
    logic [15:0] misrGood  [0:NVEC];
    logic [15:0] misrFault [0:NVEC];

    int  testsRun   = 0;
    int  failures   = 0;
    int  edgeCount  = 0;
    int  startEdge  = 0;
    int  doneAt     = -1;
    bit  trackRun   = 0;
    bit  faultMode  = 0;
    logic flip;

    alu_bist_seq #(
        .NUM_OPS    (NOPS),
        .ROUNDS     (NRND),
        .LFSR_SEED  (16'hACE1),
        .GOLDEN_SIG (GOLDEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .start     (start),
        .abort     (abort),
        .alu_ctrl  (aluCtrl),
        .alu_x     (aluX),
        .alu_y     (aluY),
        .alu_out   (aluOut),
        .alu_carry (aluCarry),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature)
    );

    assign flip = faultMode && (aluCtrl == 4'd4) && ({aluX, aluY} == lfsrVec[FAULTV]);
    assign {aluCarry, aluOut} = aluModel(aluCtrl, aluX, aluY) ^ {8'b0, flip};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Records the first done pulse of the current run relative to its start edge
    always @(negedge clk) begin
        if (done && doneAt < 0) doneAt = edgeCount - startEdge;
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit a);
        start = s;
        abort = a;
    endtask

    function automatic logic [15:0] sigAt(input int idx);
        sigAt = faultMode ? misrFault[idx] : misrGood[idx];
    endfunction

    // Expected outputs t edges after the start-sampling edge
    task automatic compareCycle(input int t);
        logic [3:0]  eCtrl;
        logic [7:0]  eX;
        logic [7:0]  eY;
        logic        eBusy;
        logic        eDone;
        logic        ePass;
        logic [15:0] eSig;
        int          k;
        if (t < RUNLEN) begin
            k     = t / 2;
            eCtrl = 4'(k / NRND);
            eX    = lfsrVec[k][15:8];
            eY    = lfsrVec[k][7:0];
            eBusy = 1'b1;
            eDone = 1'b0;
            ePass = 1'b0;
            eSig  = sigAt(t / 2);
        end else if (t == RUNLEN) begin
            eCtrl = NOP;
            eX    = 8'h00;
            eY    = 8'h00;
            eBusy = 1'b1;
            eDone = 1'b1;
            ePass = 1'b0;
            eSig  = sigAt(NVEC);
        end else begin
            eCtrl = NOP;
            eX    = 8'h00;
            eY    = 8'h00;
            eBusy = 1'b0;
            eDone = 1'b0;
            ePass = (sigAt(NVEC) == GOLDEN);
            eSig  = sigAt(NVEC);
        end
        checkOutput($sformatf("ctrl@%0d", t), 16'(aluCtrl), 16'(eCtrl));
        checkOutput($sformatf("x@%0d", t), 16'(aluX), 16'(eX));
        checkOutput($sformatf("y@%0d", t), 16'(aluY), 16'(eY));
        checkOutput($sformatf("busy@%0d", t), 16'(busy), 16'(eBusy));
        checkOutput($sformatf("done@%0d", t), 16'(done), 16'(eDone));
        checkOutput($sformatf("pass@%0d", t), 16'(pass), 16'(ePass));
        checkOutput($sformatf("sig@%0d", t), signature, eSig);
    endtask

    // Cycle-by-cycle comparison against the vector model while a run is tracked
    always @(negedge clk) begin
        int tRel;
        tRel = edgeCount - startEdge;
        if (trackRun && rstN && tRel >= 0) compareCycle(tRel);
    end

    task automatic buildModel();
        logic [15:0] l;
        logic [8:0]  r;
        logic [3:0]  op;
        l = 16'hACE1;
        misrGood[0]  = 16'h0000;
        misrFault[0] = 16'h0000;
        for (int i = 0; i < NVEC; i++) begin
            lfsrVec[i] = l;
            op = 4'(i / NRND);
            r  = aluModel(op, l[15:8], l[7:0]);
            misrGood[i+1] = {misrGood[i][14:0], misrGood[i][15] ^ misrGood[i][13] ^ misrGood[i][12] ^ misrGood[i][10]}
                            ^ {7'b0, (op <= 4'd1) ? r[8] : 1'b0, r[7:0]};
            if (i == FAULTV) r[0] = ~r[0];
            misrFault[i+1] = {misrFault[i][14:0], misrFault[i][15] ^ misrFault[i][13] ^ misrFault[i][12] ^ misrFault[i][10]}
                             ^ {7'b0, (op <= 4'd1) ? r[8] : 1'b0, r[7:0]};
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
    endtask

    task automatic startRun(input bit fault);
        #1;
        faultMode = fault;
        doneAt    = -1;
        startEdge = edgeCount + 1;
        applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0);
        trackRun = 1'b1;
    endtask

    task automatic waitRel(input int n);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((edgeCount - startEdge) != n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) begin
            testsRun++;
            failures++;
            $display("[TB] FAIL waitRel: got timeout expected offset %0d", n);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Ctrl"}, 16'(aluCtrl), 16'(NOP));
        checkOutput({tag, "X"}, 16'(aluX), 16'h0000);
        checkOutput({tag, "Y"}, 16'(aluY), 16'h0000);
        checkOutput({tag, "Busy"}, 16'(busy), 16'h0000);
        checkOutput({tag, "Done"}, 16'(done), 16'h0000);
        checkOutput({tag, "Pass"}, 16'(pass), 16'h0000);
        checkOutput({tag, "Sig"}, signature, 16'h0000);
    endtask

    task automatic checkRunEnd(input string tag, input logic expPass, input logic [15:0] expSig);
        checkOutput({tag, "DoneAt"}, 16'(doneAt), 16'(RUNLEN));
        checkOutput({tag, "Pass"}, 16'(pass), 16'(expPass));
        checkOutput({tag, "Sig"}, signature, expSig);
    endtask

    initial begin
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0);
        buildModel();

        // Pin the model to hand-computed values
        checkOutput("modelLfsr0", lfsrVec[0], 16'hACE1);
        checkOutput("modelLfsr1", lfsrVec[1], 16'h59C3);
        checkOutput("modelGolden", misrGood[NVEC], GOLDEN);
        checkOutput("modelAdd", 16'(aluModel(4'd0, 8'hAC, 8'hE1)), 16'h018D);
        checkOutput("modelFaultDiffers", 16'(misrFault[NVEC] != misrGood[NVEC]), 16'h0001);

        // Reset with clock running
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rstN = 1'b1;
        @(negedge clk);

        // Golden run with directed vector checks
        startRun(1'b0);
        waitRel(0);
        checkOutput("vec0Ctrl", 16'(aluCtrl), 16'h0000);
        checkOutput("vec0X", 16'(aluX), 16'h00AC);
        checkOutput("vec0Y", 16'(aluY), 16'h00E1);
        waitRel(2);
        checkOutput("vec1X", 16'(aluX), 16'h0059);
        checkOutput("vec1Y", 16'(aluY), 16'h00C3);
        waitRel(32);
        checkOutput("vec16Ctrl", 16'(aluCtrl), 16'h0001);
        waitRel(446);
        checkOutput("vec223Ctrl", 16'(aluCtrl), 16'h000D);
        waitRel(RUNLEN + 1);
        checkRunEnd("golden", 1'b1, GOLDEN);

        // Back-to-back fault-injection run
        startRun(1'b1);
        waitRel(RUNLEN + 1);
        checkRunEnd("fault", 1'b0, misrFault[NVEC]);
        checkOutput("faultSigNotGolden", 16'(signature != GOLDEN), 16'h0001);

        // Ignored start mid-run, then abort
        startRun(1'b0);
        waitRel(100);
        applyStimulus(1'b1, 1'b0);
        waitRel(101);
        applyStimulus(1'b0, 1'b0);
        waitRel(200);
        trackRun = 1'b0;
        applyStimulus(1'b0, 1'b1);
        waitRel(201);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abortBusy", 16'(busy), 16'h0000);
        checkOutput("abortCtrl", 16'(aluCtrl), 16'(NOP));
        checkOutput("abortX", 16'(aluX), 16'h0000);
        checkOutput("abortPass", 16'(pass), 16'h0000);
        checkOutput("abortSig", signature, misrGood[100]);
        repeat (10) @(negedge clk);
        checkOutput("abortNoDone", 16'(doneAt < 0), 16'h0001);

        // Abort and start together in IDLE: abort wins
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abortStartBusy", 16'(busy), 16'h0000);
        @(negedge clk);
        checkOutput("abortStartBusy2", 16'(busy), 16'h0000);
        checkOutput("abortStartCtrl", 16'(aluCtrl), 16'(NOP));

        // Asynchronous reset mid-run, then a fresh golden run
        startRun(1'b0);
        waitRel(240);
        trackRun = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        checkResetValues("asyncReset");
        @(negedge clk);
        checkResetValues("heldReset");
        rstN = 1'b1;
        @(negedge clk);
        startRun(1'b0);
        waitRel(RUNLEN + 1);
        checkRunEnd("afterReset", 1'b1, GOLDEN);
        trackRun = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
